ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV-M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Works on operand magnitudes and applies the sign in FIN. Multiply is shift-add and divide
// is restoring radix-2, one step per clock. Divide-by-zero and signed overflow bypass CALC.
// Optional macro EX_MULDIV_FAST_MUL_EN: multiplies form the full product in one cycle and
// bypass CALC. Divide is unaffected.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] rd_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] rd_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t             state_q;
    logic [2:0]         op_q;
    logic [TAG_W-1:0]   rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               spec_q;
    logic [XLEN-1:0]    spec_res_q;
    logic [XLEN-1:0]    opnd_q;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0]  prod_q;      // low half starts as multiplier, fills with product
    logic [XLEN-1:0]    quo_q;       // starts as dividend magnitude, shifts in quotient bits
    logic [XLEN:0]      rem_q;

    // operand decode
    logic               a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic               neg_res, div0, ovf;
    logic [XLEN-1:0]    spec_val;

    // iteration step
    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  prod_d;
    logic [XLEN+1:0]    div_shift, div_diff;
    logic               div_ge;
    logic [XLEN:0]      rem_d;
    logic [XLEN-1:0]    quo_d;
    logic [CNT_W-1:0]   cnt_d;

    // final correction
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quo_fix, rem_fix, fin_res;

`ifdef EX_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]  prod_fast;
`endif

    // Decode signedness, magnitudes, result sign and the special divide cases.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        unique case (op_i)
            3'b001:  begin a_signed = 1'b1; b_signed = 1'b1; end  // MULH
            3'b010:  a_signed = 1'b1;                             // MULHSU
            3'b100:  begin a_signed = 1'b1; b_signed = 1'b1; end  // DIV
            3'b110:  begin a_signed = 1'b1; b_signed = 1'b1; end  // REM
            default: ;
        endcase
        a_neg   = a_signed & a_i[XLEN-1];
        b_neg   = b_signed & b_i[XLEN-1];
        a_mag   = a_neg ? ('0 - a_i) : a_i;
        b_mag   = b_neg ? ('0 - b_i) : b_i;
        // A remainder follows the dividend; products and quotients follow the sign product.
        neg_res = (op_i[2] & op_i[1]) ? a_neg : (a_neg ^ b_neg);
        div0    = op_i[2] & (b_i == '0);
        ovf     = op_i[2] & ~op_i[0] & (a_i == MOST_NEG) & (b_i == '1);
        spec_val = '0;
        if (div0)
            spec_val = op_i[1] ? a_i : '1;
        else if (ovf)
            spec_val = op_i[1] ? '0 : a_i;
    end

`ifdef EX_MULDIV_FAST_MUL_EN
    // Single-cycle full-width magnitude product.
    always_comb begin
        prod_fast = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    end
`endif

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        prod_d    = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]} : {1'b0, prod_q[2*XLEN-1:1]};
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_diff  = div_shift - {2'b00, opnd_q};
        div_ge    = ~div_diff[XLEN+1];
        rem_d     = div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
        quo_d     = {quo_q[XLEN-2:0], div_ge};
        cnt_d     = cnt_q - 1'b1;
    end

    // Sign correction and half / quotient / remainder selection for FIN.
    always_comb begin
        prod_fix = neg_q ? ('0 - prod_q) : prod_q;
        quo_fix  = neg_q ? ('0 - quo_q) : quo_q;
        rem_fix  = neg_q ? ('0 - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
        if (spec_q)
            fin_res = spec_res_q;
        else if (op_q[2])
            fin_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q[1:0] == 2'b00)
            fin_res = prod_fix[XLEN-1:0];
        else
            fin_res = prod_fix[2*XLEN-1:XLEN];
    end

    // Stall whenever busy, or when a start is about to be accepted.
    always_comb begin
        stall_o = (start_i & ~flush_i & (state_q == S_IDLE)) | (state_q != S_IDLE);
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            opnd_q     <= '0;
            prod_q     <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            done_o     <= 1'b0;
            result_o   <= '0;
            rd_o       <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        op_q       <= op_i;
                        rd_q       <= rd_i;
                        neg_q      <= neg_res;
                        spec_q     <= div0 | ovf;
                        spec_res_q <= spec_val;
                        opnd_q     <= op_i[2] ? b_mag : a_mag;
                        prod_q     <= {{XLEN{1'b0}}, b_mag};
                        quo_q      <= a_mag;
                        rem_q      <= '0;
                        cnt_q      <= CNT_INIT;
                        if (div0 || ovf)
                            state_q <= S_FIN;
`ifdef EX_MULDIV_FAST_MUL_EN
                        else if (!op_i[2]) begin
                            prod_q  <= prod_fast;
                            state_q <= S_FIN;
                        end
`endif
                        else
                            state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (op_q[2]) begin
                            quo_q <= quo_d;
                            rem_q <= rem_d;
                        end else begin
                            prod_q <= prod_d;
                        end
                        cnt_q <= cnt_d;
                        if (cnt_d == '0)
                            state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    if (!flush_i) begin
                        result_o <= fin_res;
                        rd_o     <= rd_q;
                        done_o   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit at XLEN=32 with hand-computed expected results.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;

`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT  = 33;
    localparam int SPEC_LAT = 1;

    ex_muldiv_unit #(.XLEN(32), .TAG_W(5), .CNT_W(6)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .rd_i     (rd_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called away from a rising edge; the request is sampled at the next rising edge (E).
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        rd_i    = rd;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Counts cycles after E until done_o; returns at the falling edge of the done cycle.
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_rd,
                             input int exp_lat);
        int k = 0;
        logic stall_gap = 1'b0;
        @(negedge clk);
        while (!done_o && k < 200) begin
            if (!stall_o) stall_gap = 1'b1;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check({tag, "_done"},   {63'd0, done_o}, 64'd1);
        check({tag, "_result"}, {32'd0, result_o}, {32'd0, exp_res});
        check({tag, "_rd"},     {59'd0, rd_o}, {59'd0, exp_rd});
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_stall_busy"}, {63'd0, stall_gap}, 64'd0);
        check({tag, "_stall_done"}, {63'd0, stall_o}, 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        logic        seen;

        reset_n = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;
        rd_i    = '0;
        repeat (3) @(negedge clk);
        check("reset_done",   {63'd0, done_o}, 64'd0);
        check("reset_result", {32'd0, result_o}, 64'd0);
        check("reset_rd",     {59'd0, rd_o}, 64'd0);
        check("reset_stall",  {63'd0, stall_o}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Multiply family
        start_i = 1'b1; op_i = OP_MUL;
        #1 check("start_stall", {63'd0, stall_o}, 64'd1);
        start_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd9);
        wait_done("mul", 32'hFFFF_FFEB, 5'd9, MUL_LAT);
        @(negedge clk);
        check("done_pulse", {63'd0, done_o}, 64'd0);
        start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        wait_done("mulhu", 32'hFFFF_FFFE, 5'd1, MUL_LAT);
        start_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        wait_done("mulh", 32'h0000_0000, 5'd2, MUL_LAT);
        start_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3);
        wait_done("mulhsu", 32'hFFFF_FFFF, 5'd3, MUL_LAT);

        // Divide family
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4);
        wait_done("div", 32'hFFFF_FFFD, 5'd4, DIV_LAT);
        start_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd5);
        wait_done("rem", 32'hFFFF_FFFF, 5'd5, DIV_LAT);
        start_op(OP_DIVU, 32'd100, 32'd7, 5'd6);
        wait_done("divu", 32'd14, 5'd6, DIV_LAT);
        start_op(OP_REMU, 32'd100, 32'd7, 5'd7);
        wait_done("remu", 32'd2, 5'd7, DIV_LAT);

        // Special divide cases
        start_op(OP_DIV, 32'h0000_1234, 32'd0, 5'd8);
        wait_done("div0", 32'hFFFF_FFFF, 5'd8, SPEC_LAT);
        start_op(OP_REM, 32'h0000_1234, 32'd0, 5'd10);
        wait_done("rem0", 32'h0000_1234, 5'd10, SPEC_LAT);
        start_op(OP_DIVU, 32'h0000_1234, 32'd0, 5'd11);
        wait_done("divu0", 32'hFFFF_FFFF, 5'd11, SPEC_LAT);
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        wait_done("div_ovf", 32'h8000_0000, 5'd12, SPEC_LAT);
        start_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        wait_done("rem_ovf", 32'h0000_0000, 5'd13, SPEC_LAT);

        // Flush mid-CALC
        held = result_o;
        start_op(OP_DIVU, 32'd1000, 32'd10, 5'd14);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        check("flush_stall",  {63'd0, stall_o}, 64'd0);
        check("flush_result", {32'd0, result_o}, {32'd0, held});
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_no_done", {63'd0, seen}, 64'd0);
        start_op(OP_DIVU, 32'd1000, 32'd10, 5'd15);
        wait_done("after_flush", 32'd100, 5'd15, DIV_LAT);

        // start_i together with flush_i is dropped
        held = result_o;
        start_i = 1'b1; flush_i = 1'b1; op_i = OP_MUL; a_i = 32'd3; b_i = 32'd5; rd_i = 5'd16;
        #1 check("startflush_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1 begin start_i = 1'b0; flush_i = 1'b0; end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o || stall_o) seen = 1'b1;
        end
        check("startflush_idle", {63'd0, seen}, 64'd0);
        check("startflush_result", {32'd0, result_o}, {32'd0, held});

        // Asynchronous reset mid-CALC (result_o is nonzero beforehand)
        start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("areset_result", {32'd0, result_o}, 64'd0);
        check("areset_rd",     {59'd0, rd_o}, 64'd0);
        check("areset_stall",  {63'd0, stall_o}, 64'd0);
        check("areset_done",   {63'd0, done_o}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        check("areset_no_done", {63'd0, seen}, 64'd0);

        // Back-to-back multiplies issued in the done cycle
        start_op(OP_MUL, 32'd6, 32'd7, 5'd20);
        wait_done("b2b_1", 32'd42, 5'd20, MUL_LAT);
        start_op(OP_MUL, 32'hFFFF_FFFF, 32'd5, 5'd21);
        wait_done("b2b_2", 32'hFFFF_FFFB, 5'd21, MUL_LAT);
        start_op(OP_MULHU, 32'h8000_0000, 32'd4, 5'd22);
        wait_done("b2b_3", 32'd2, 5'd22, MUL_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
